// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word width, underrun fill word and responder state type
package spi_pkg;

    localparam int         SPI_WIDTH      = 8;
    localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchronizer with rise/fall pulses on the synced level
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_interface.sv
// rtl/spi_slave_interface.sv - SPI mode-0 responder, MSB first, oversampled in the clk domain
module spi_slave_interface
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(SPI_DEFAULT_TX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  chip_select,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (chip_select),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk synchronizer so the sampled bit lines up with the detected rise.
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic                   mosi_s;

    spi_state_t            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_underrun_q, tx_underrun_d;

    logic                  load;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] rx_word;

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_comb begin
        mosi_d        = {mosi_q[SYNC_STAGES-2:0], mosi};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        load          = 1'b0;
        load_word     = hold_full_q ? hold_q : DEFAULT_TX;
        rx_word       = {rx_shift_q, mosi_s};

        case (state_q)
            SPI_IDLE: begin
                bit_cnt_d = '0;
                miso_d    = 1'b0;
                if (cs_fall) begin
                    state_d = SPI_ACTIVE;
                    load    = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                // Deselect takes priority over a coincident rise; a partial word is dropped.
                if (cs_rise) begin
                    state_d   = SPI_IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_WIDTH-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        load       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                    end else begin
                        miso_d = tx_shift_q[DATA_WIDTH-1];
                    end
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        if (load) begin
            tx_shift_d = load_word;
            miso_d     = load_word[DATA_WIDTH-1];
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else begin
                tx_underrun_d = 1'b1;
            end
        end

        // A write accepted alongside a load is kept for the following word.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q        <= '0;
            state_q       <= SPI_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            miso_q        <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            mosi_q        <= mosi_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == SPI_ACTIVE);
    assign busy        = (state_q == SPI_ACTIVE);
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// tb/tb_spi_slave_interface.sv - master-model bench for spi_slave_interface
module tb_spi_slave_interface;

    localparam logic [7:0] DEF_TX = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       chip_select = 1'b1;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_interface dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .chip_select (chip_select),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    typedef struct packed {
        int              nw;
        int              abort_bit;
        int              npre;
        int              ntx;
        logic [2:0][7:0] mo;
        logic [2:0][7:0] tx;
        int              nrx;
        logic [2:0][7:0] exp_rd;
        logic [2:0][7:0] exp_rx;
        int              exp_und;
    } vec_t;

    vec_t vt [5];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q [$];
    int         und_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (tx_underrun === 1'b1) und_cnt++;
    end

    // Reference: one holding slot, a word popped at select and at every completed word.
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    int         m_und  = 0;

    logic [7:0] rd_q [$];
    logic [7:0] exp_rd [$];
    logic [7:0] exp_rx [$];
    logic [2:0][7:0] mw;
    logic [2:0][7:0] txw;
    int ntx, txi, und0, mund0, und_words;

    function automatic logic [7:0] m_load();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        m_und++;
        return DEF_TX;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
    endtask

    task automatic try_write();
        chk("tx_ready_model", 32'(tx_ready), 32'(!m_full));
        if (!m_full && txi < ntx) begin
            tx_data  = txw[txi];
            tx_valid = 1'b1;
            wait_clk(1);
            tx_valid = 1'b0;
            m_hold   = txw[txi];
            m_full   = 1'b1;
            txi++;
        end else begin
            wait_clk(1);
        end
    endtask

    task automatic xfer(input int nw, input int abort_bit, input int rst_bit);
        logic [7:0] shift, got;
        bit stop;
        stop = 1'b0;
        rd_q.delete(); exp_rd.delete(); exp_rx.delete(); rx_q.delete();
        und0 = und_cnt; mund0 = m_und; und_words = 0;
        chip_select = 1'b0;
        shift = m_load();
        for (int w = 0; w < nw && !stop; w++) begin
            got = 8'h00;
            for (int b = 0; b < 8 && !stop; b++) begin
                if (w == nw - 1 && b == abort_bit) begin
                    stop = 1'b1;
                end else if (w == 0 && b == rst_bit) begin
                    rst = 1'b1; chip_select = 1'b1; sclk = 1'b0; mosi = 1'b0;
                    wait_clk(2);
                    check_reset("mid_rst");
                    rst = 1'b0;
                    m_full = 1'b0;
                    stop = 1'b1;
                end else begin
                    mosi = mw[w][7 - b];
                    wait_clk(5);
                    got[7 - b] = miso;
                    if (w == nw - 1 && b == 7) und_words = und_cnt - und0;
                    sclk = 1'b1;
                    if (w == 0 && b == 0) begin
                        chk("busy_sel", 32'(busy), 32'd1);
                        chk("miso_oe_sel", 32'(miso_oe), 32'd1);
                    end
                    if (b == 3) try_write(); else wait_clk(1);
                    wait_clk(4);
                    sclk = 1'b0;
                end
            end
            if (!stop) begin
                rd_q.push_back(got);
                exp_rd.push_back(shift);
                exp_rx.push_back(mw[w]);
                shift = m_load();
            end
        end
        if (rst_bit < 0) begin
            if (stop) und_words = und_cnt - und0;
            wait_clk(5);
            chip_select = 1'b1;
            wait_clk(10);
            chk("busy_desel", 32'(busy), 32'd0);
        end else begin
            wait_clk(5);
        end
    endtask

    task automatic check_model(input string tag);
        foreach (rd_q[i]) chk($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(exp_rd[i]));
        chk({tag, "_nrx"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        if (rx_q.size() == exp_rx.size())
            foreach (rx_q[i]) chk($sformatf("%s_rx%0d", tag, i), 32'(rx_q[i]), 32'(exp_rx[i]));
        chk({tag, "_und"}, 32'(und_cnt - und0), 32'(m_und - mund0));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        mw  = v.mo;
        txw = v.tx;
        ntx = v.ntx;
        txi = 0;
        if (v.npre > 0) try_write();
        xfer(v.nw, v.abort_bit, -1);
        check_model(tag);
        chk({tag, "_tbl_nrx"}, 32'(rx_q.size()), 32'(v.nrx));
        for (int i = 0; i < v.nrx && i < rx_q.size() && i < rd_q.size(); i++) begin
            chk($sformatf("%s_tbl_rd%0d", tag, i), 32'(rd_q[i]), 32'(v.exp_rd[i]));
            chk($sformatf("%s_tbl_rx%0d", tag, i), 32'(rx_q[i]), 32'(v.exp_rx[i]));
        end
        chk({tag, "_tbl_und"}, 32'(und_words), 32'(v.exp_und));
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int k_acc;
        bit blocked_ok;

        vt[0] = '{nw:1, abort_bit:-1, npre:1, ntx:1,
                  mo:{8'h00, 8'h00, 8'h29}, tx:{8'h00, 8'h00, 8'hAB}, nrx:1,
                  exp_rd:{8'h00, 8'h00, 8'hAB}, exp_rx:{8'h00, 8'h00, 8'h29}, exp_und:0};
        vt[1] = '{nw:3, abort_bit:-1, npre:1, ntx:3,
                  mo:{8'h55, 8'h66, 8'h77}, tx:{8'h3C, 8'h91, 8'h66}, nrx:3,
                  exp_rd:{8'h3C, 8'h91, 8'h66}, exp_rx:{8'h55, 8'h66, 8'h77}, exp_und:0};
        vt[2] = '{nw:1, abort_bit:-1, npre:0, ntx:0,
                  mo:{8'h00, 8'h00, 8'hA5}, tx:{8'h00, 8'h00, 8'h00}, nrx:1,
                  exp_rd:{8'h00, 8'h00, 8'hFF}, exp_rx:{8'h00, 8'h00, 8'hA5}, exp_und:1};
        vt[3] = '{nw:1, abort_bit:5, npre:0, ntx:0,
                  mo:{8'h00, 8'h00, 8'hC3}, tx:{8'h00, 8'h00, 8'h00}, nrx:0,
                  exp_rd:{8'h00, 8'h00, 8'h00}, exp_rx:{8'h00, 8'h00, 8'h00}, exp_und:1};
        vt[4] = '{nw:1, abort_bit:-1, npre:0, ntx:0,
                  mo:{8'h00, 8'h00, 8'h5A}, tx:{8'h00, 8'h00, 8'h00}, nrx:1,
                  exp_rd:{8'h00, 8'h00, 8'hFF}, exp_rx:{8'h00, 8'h00, 8'h5A}, exp_und:1};

        wait_clk(3);
        check_reset("reset");
        rst = 1'b0;
        wait_clk(3);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset at bit 4 of a transfer, then a clean transfer.
        txw[0] = 8'hE7; ntx = 1; txi = 0;
        try_write();
        mw = {8'h00, 8'h00, 8'h96};
        xfer(1, -1, 4);
        txw[0] = 8'h3E; ntx = 1; txi = 0;
        try_write();
        mw = {8'h00, 8'h00, 8'hC8};
        xfer(1, -1, -1);
        check_model("post_rst");
        if (rd_q.size() > 0) chk("post_rst_rd", 32'(rd_q[0]), 32'h3E);

        // tx_valid held while holding is full.
        txw[0] = 8'hA1; ntx = 1; txi = 0;
        try_write();
        tx_data = 8'h12;
        tx_valid = 1'b1;
        blocked_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (tx_ready !== 1'b0) blocked_ok = 1'b0;
            wait_clk(1);
        end
        chk("hs_blocked", 32'(blocked_ok), 32'd1);
        mw = {8'h00, 8'h3B, 8'hD4}; ntx = 0; txi = 0;
        fork
            xfer(2, -1, -1);
            begin
                k_acc = -1;
                for (int k = 0; k < 40; k++) begin
                    if (k_acc < 0 && tx_ready === 1'b1) k_acc = k;
                    wait_clk(1);
                    if (k_acc >= 0) break;
                end
                tx_valid = 1'b0;
                chk("hs_after_load", 32'(k_acc >= 3), 32'd1);
                if (k_acc >= 0) begin
                    m_hold = 8'h12;
                    m_full = 1'b1;
                end
            end
        join
        check_model("hs");
        if (rd_q.size() == 2) begin
            chk("hs_rd0", 32'(rd_q[0]), 32'hA1);
            chk("hs_rd1", 32'(rd_q[1]), 32'h12);
        end else begin
            chk("hs_nrd", 32'(rd_q.size()), 32'd2);
        end

        for (int r = 0; r < 8; r++) begin
            int nw, ab;
            nw = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) begin
                mw[i]  = 8'($urandom);
                txw[i] = 8'($urandom);
            end
            ntx = $urandom_range(0, nw);
            txi = 0;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
            if (ntx > 0 && $urandom_range(0, 1) == 1) try_write();
            xfer(nw, ab, -1);
            check_model($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
